// File: rtl/mem_access_unit.sv
// Request sequencer between the processor datapath and the cache/RAM memory module.
// Handles one read/write at a time, resolves indirect addresses, and bounds every memory wait.
module mem_access_unit #(
  parameter int ramWidth      = 8,
  parameter int addrSize      = 8,
  parameter int timeoutCycles = 255
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req,
  input  logic [1:0]          op,
  input  logic                indirect,
  input  logic [addrSize-1:0] addr,
  input  logic [ramWidth-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ramWidth-1:0] rdata,
  output logic                mem_start,
  output logic [1:0]          mem_cntrl,
  output logic [addrSize-1:0] mem_addr,
  output logic [ramWidth-1:0] mem_dataIn,
  output logic                mem_isIndirect,
  input  logic [ramWidth-1:0] mem_dataOut,
  input  logic                mem_dataReady
);

  localparam int cntWidth = $clog2(timeoutCycles + 1);
  localparam logic [cntWidth-1:0] cntLast = cntWidth'(timeoutCycles - 1);
  localparam logic [1:0] opRead  = 2'b01;
  localparam logic [1:0] opWrite = 2'b10;
  localparam logic [1:0] opIdle  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    PTR_ISSUE,
    PTR_WAIT,
    ACC_ISSUE,
    ACC_WAIT,
    DONE,
    ERR
  } state_t;

  state_t              state, nextState;
  logic [1:0]          opQ, opD;
  logic [ramWidth-1:0] wdataQ, wdataD;
  logic [cntWidth-1:0] waitCnt, cntD;
  logic                readyPrev;
  logic                readySeen;
  logic                timedOut;

  logic                busyD, doneD, errD, startD, isIndD;
  logic [ramWidth-1:0] rdataD, dataInD;
  logic [1:0]          cntrlD;
  logic [addrSize-1:0] addrD;

  // Only the rising edge of dataReady completes a wait, so a level left high by
  // the memory module across the pointer fetch cannot complete the second access.
  assign readySeen = mem_dataReady && !readyPrev;
  assign timedOut  = !readySeen && (waitCnt == cntLast);

  // Every output is computed here for the state being entered and registered below.
  always_comb begin
    // NOTE: each signal starts from its hold/default value so no path leaves it
    // unassigned, which would otherwise infer a latch.
    nextState = state;
    opD       = opQ;
    wdataD    = wdataQ;
    cntD      = waitCnt;
    busyD     = busy;
    doneD     = 1'b0;
    errD      = 1'b0;
    rdataD    = rdata;
    startD    = 1'b0;
    cntrlD    = mem_cntrl;
    addrD     = mem_addr;
    dataInD   = mem_dataIn;
    isIndD    = mem_isIndirect;

    unique case (state)
      IDLE: begin
        if (req) begin
          if (op == opRead || op == opWrite) begin
            opD    = op;
            wdataD = wdata;
            busyD  = 1'b1;
            startD = 1'b1;
            addrD  = addr;
            if (indirect) begin
              nextState = PTR_ISSUE;
              cntrlD    = opRead;
              isIndD    = 1'b1;
            end else begin
              nextState = ACC_ISSUE;
              cntrlD    = op;
              dataInD   = wdata;
              isIndD    = 1'b0;
            end
          end else begin
            nextState = ERR;
            doneD     = 1'b1;
            errD      = 1'b1;
          end
        end
      end

      PTR_ISSUE: begin
        nextState = PTR_WAIT;
        cntD      = '0;
      end

      PTR_WAIT: begin
        if (readySeen) begin
          nextState = ACC_ISSUE;
          startD    = 1'b1;
          cntrlD    = opQ;
          addrD     = mem_dataOut[addrSize-1:0];
          dataInD   = wdataQ;
        end else if (timedOut) begin
          nextState = ERR;
          doneD     = 1'b1;
          errD      = 1'b1;
          busyD     = 1'b0;
          cntrlD    = opIdle;
          isIndD    = 1'b0;
        end else begin
          cntD = waitCnt + cntWidth'(1);
        end
      end

      ACC_ISSUE: begin
        nextState = ACC_WAIT;
        cntD      = '0;
      end

      ACC_WAIT: begin
        if (readySeen) begin
          nextState = DONE;
          doneD     = 1'b1;
          busyD     = 1'b0;
          cntrlD    = opIdle;
          isIndD    = 1'b0;
          if (opQ == opRead) rdataD = mem_dataOut;
        end else if (timedOut) begin
          nextState = ERR;
          doneD     = 1'b1;
          errD      = 1'b1;
          busyD     = 1'b0;
          cntrlD    = opIdle;
          isIndD    = 1'b0;
        end else begin
          cntD = waitCnt + cntWidth'(1);
        end
      end

      DONE, ERR: nextState = IDLE;

      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= IDLE;
      opQ            <= opIdle;
      wdataQ         <= '0;
      waitCnt        <= '0;
      readyPrev      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= '0;
      mem_start      <= 1'b0;
      mem_cntrl      <= opIdle;
      mem_addr       <= '0;
      mem_dataIn     <= '0;
      mem_isIndirect <= 1'b0;
    end else begin
      state          <= nextState;
      opQ            <= opD;
      wdataQ         <= wdataD;
      waitCnt        <= cntD;
      readyPrev      <= mem_dataReady;
      busy           <= busyD;
      done           <= doneD;
      err            <= errD;
      rdata          <= rdataD;
      mem_start      <= startD;
      mem_cntrl      <= cntrlD;
      mem_addr       <= addrD;
      mem_dataIn     <= dataInD;
      mem_isIndirect <= isIndD;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Request sequencer directly upstream of the cache/RAM memory module; the processor datapath talks to this block, never to the memory module.
- Accepts one read or write request, drives the module's start/cntrl/addr/dataIn/isIndirect inputs, waits for its dataReady, and returns a registered result with a one-cycle done pulse.
- Resolves indirect addressing as two module accesses: a pointer fetch, then the real access at the fetched address.
- Adds a wait timeout so a hung memory access cannot stall the processor.

Parameters:
- ramWidth, 8, data word width; must be >= addrSize.
- addrSize, 8, address width.
- timeoutCycles, 255, maximum cycles spent in a WAIT state before abort; counter width is ceil(log2(timeoutCycles+1)).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- op  in  2  01 read, 10 write, 00/11 illegal.
- indirect  in  1  addr holds a pointer to the effective address.
- addr  in  addrSize  request address (or pointer address).
- wdata  in  ramWidth  write data.
- busy  out  1  high from the cycle after acceptance until DONE/ERR exits.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on illegal op or timeout.
- rdata  out  ramWidth  read result; holds until the next completed read.
- mem_start  out  1  one-cycle start pulse to the memory module.
- mem_cntrl  out  2  01 read, 10 write, 00 idle.
- mem_addr  out  addrSize  address to the memory module.
- mem_dataIn  out  ramWidth  write data to the memory module.
- mem_isIndirect  out  1  high for the whole of an indirect operation.
- mem_dataOut  in  ramWidth  memory module read data.
- mem_dataReady  in  1  memory module completion.

Behaviour:
- Reset (clr high at a clock edge, from any state including mid-operation): state IDLE; busy, done, err, mem_start, mem_isIndirect = 0; mem_cntrl = 00; rdata, mem_addr, mem_dataIn, timeout counter = 0. The aborted access is dropped and not replayed.
- All outputs are registered.
- IDLE:
  - req with op 01/10: latch op, indirect, addr, wdata. Go to PTR_ISSUE if indirect, else ACC_ISSUE.
  - req with op 00/11: go to ERR; no memory access.
- PTR_ISSUE: one cycle; mem_start=1, mem_cntrl=01, mem_addr=latched addr, mem_isIndirect=1. Then PTR_WAIT.
- PTR_WAIT: mem_start=0, mem_cntrl held.
  - First cycle mem_dataReady=1: effective address = mem_dataOut[addrSize-1:0]; go to ACC_ISSUE.
- ACC_ISSUE: one cycle; mem_start=1, mem_cntrl=latched op, mem_addr=effective address (latched addr if direct), mem_dataIn=latched wdata. Then ACC_WAIT.
- ACC_WAIT:
  - First cycle mem_dataReady=1: for reads, capture mem_dataOut into rdata; go to DONE.
- DONE: done=1 for one cycle, busy=0, mem_cntrl=00, mem_isIndirect=0. Then IDLE.
- ERR: done=1 and err=1 for one cycle; rdata unchanged. Then IDLE.
- Timeout:
  - The counter clears on entry to each WAIT state and increments every WAIT cycle without dataReady.
  - If it reaches timeoutCycles with dataReady still low, go to ERR.
  - If dataReady arrives in that same cycle, dataReady wins.
- dataReady is ignored outside WAIT states; a level held high across two cycles counts once.
- req during busy/DONE/ERR is ignored, not queued. A new request is first accepted in the IDLE cycle after done.
- Direct-op latency: req at edge 0 → mem_start at cycle 1 → dataReady first seen at cycle k → done at cycle k+1.
- Writes never modify rdata. The pointer fetch never modifies rdata.

Test Plan:
- Direct read: clr, then req op=01 addr=0x12; memory model returns 0xA5 with dataReady 3 cycles after start → exactly one mem_start with cntrl=01 addr=0x12; done pulse with rdata=0xA5, err=0; busy low after done.
- Direct write: req op=10 addr=0x30 wdata=0x5C → mem_start with cntrl=10, mem_addr=0x30, mem_dataIn=0x5C; done pulse; rdata keeps previous 0xA5.
- Indirect read: RAM[0x04]=0x40, RAM[0x40]=0x99; req op=01 indirect=1 addr=0x04 → two mem_starts (addr 0x04, then 0x40); mem_isIndirect high throughout; rdata=0x99.
- Illegal op and busy request: req op=11 → done+err next cycle, no mem_start. Then a second req is pulsed during ACC_WAIT of a legal read → ignored; exactly one done.
- Timeout: timeoutCycles=8, memory never asserts dataReady → done+err 8 cycles after entering ACC_WAIT; next request completes normally.
- Reset mid-op: clr asserted during PTR_WAIT → next cycle all outputs zero and state IDLE. A later dataReady pulse produces no done. A fresh read then completes correctly.
